// File: rtl/systolic_pe_acc_if.sv
// Bus bundle for one systolic PE: forwarded lanes, framing controls and the result bus.
interface systolic_pe_acc_if #(
  parameter int P     = 2,
  parameter int W     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 20
);
  logic                   en;
  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic [P*DW-1:0]        up;
  logic [W*DW-1:0]        left;
  logic [P*DW-1:0]        bottom;
  logic [W*DW-1:0]        right;
  logic                   right_valid;
  logic                   right_first;
  logic                   right_last;
  logic [P*W*ACC_W-1:0]   out;
  logic                   out_valid;
  logic                   out_sat;

  modport master (
    output en, in_valid, in_first, in_last, up, left,
    input  bottom, right, right_valid, right_first, right_last, out, out_valid, out_sat
  );
  modport slave (
    input  en, in_valid, in_first, in_last, up, left,
    output bottom, right, right_valid, right_first, right_last, out, out_valid, out_sat
  );
endinterface

// File: rtl/systolic_pe_acc.sv
// Systolic PE: forwards P activation / W weight lanes and computes P*W framed dot products.
// Optional PE_SAT_EN macro enables saturating accumulation and the out_sat sticky flag.
module systolic_pe_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    v1,
  input  logic                    f1,
  input  logic                    pub,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] res
`ifdef PE_SAT_EN
  , output logic                  sat
`endif
);
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc, term, base, acc_nxt;

  assign term = ACC_W'(prod);
  // A first term restarts the sum, dropping any unfinished frame
  assign base = f1 ? '0 : acc;

`ifdef PE_SAT_EN
  logic [ACC_W:0] sum;
  assign sum = {base[ACC_W-1], base} + {term[ACC_W-1], term};
  assign sat = sum[ACC_W] ^ sum[ACC_W-1];
  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (sat) acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_nxt = base + term;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
      acc  <= '0;
      res  <= '0;
    end else if (en) begin
      prod <= a * b;
      if (v1)  acc <= acc_nxt;
      if (pub) res <= acc_nxt;
    end
  end
endmodule

module systolic_pe_acc #(
  parameter int P     = 2,
  parameter int W     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  systolic_pe_acc_if.slave    bus
);
  localparam int STAGES = 1;

  if (ACC_W < 2*DW) begin : g_bad_acc_w
    $error("systolic_pe_acc: ACC_W must be >= 2*DW");
  end

  // vld_pipe[0] is stage-1 valid, vld_pipe[STAGES] is the publish pulse
  logic [STAGES:0]                  vld_pipe;
  logic                             f1, l1, publish;
  logic [P-1:0][W-1:0][ACC_W-1:0]   res;
  logic [P*W-1:0]                   sat_vec;

  assign publish = vld_pipe[0] & l1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.bottom      <= '0;
      bus.right       <= '0;
      bus.right_valid <= 1'b0;
      bus.right_first <= 1'b0;
      bus.right_last  <= 1'b0;
      vld_pipe        <= '0;
      f1              <= 1'b0;
      l1              <= 1'b0;
    end else if (bus.en) begin
      bus.bottom      <= bus.up;
      bus.right       <= bus.left;
      bus.right_valid <= bus.in_valid;
      bus.right_first <= bus.in_first;
      bus.right_last  <= bus.in_last;
      vld_pipe[0]     <= bus.in_valid;
      vld_pipe[1]     <= publish;
      f1              <= bus.in_first;
      l1              <= bus.in_last;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out       = res;

  for (genvar p = 0; p < P; p++) begin : g_p
    for (genvar w = 0; w < W; w++) begin : g_w
      systolic_pe_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .v1    (vld_pipe[0]),
        .f1    (f1),
        .pub   (publish),
        .a     (bus.up[p*DW +: DW]),
        .b     (bus.left[w*DW +: DW]),
        .res   (res[p][w])
`ifdef PE_SAT_EN
        , .sat (sat_vec[p*W+w])
`endif
      );
`ifndef PE_SAT_EN
      assign sat_vec[p*W+w] = 1'b0;
`endif
    end
  end

`ifdef PE_SAT_EN
  logic sat_flag, flag_nxt;
  // Sticky per frame: a first term starts clean, any clamping lane sets it
  assign flag_nxt = (f1 ? 1'b0 : sat_flag) | (|sat_vec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag    <= 1'b0;
      bus.out_sat <= 1'b0;
    end else if (bus.en && vld_pipe[0]) begin
      sat_flag <= flag_nxt;
      if (l1) bus.out_sat <= flag_nxt;
    end
  end
`else
  assign bus.out_sat = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_pe_acc.sv
// Randomized bench for systolic_pe_acc against a frame-level integer reference model.
module tb_systolic_pe_acc;
  localparam int P = 2, W = 2, DW = 8, ACC_W = 16;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_pe_acc_if #(.P(P), .W(W), .DW(DW), .ACC_W(ACC_W)) bus ();
  systolic_pe_acc #(.P(P), .W(W), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_err = 0, pulses = 0;

  // reference state: integer partial sums per lane pair, plus the beat awaiting its product
  longint m_acc [P][W];
  longint m_out [P][W];
  bit m_flag, m_sat, m_valid;
  bit pv, pf, pl;
  longint pa [P];
  longint pb [W];
  logic [P*DW-1:0] m_bottom;
  logic [W*DW-1:0] m_right;
  bit m_rv, m_rf, m_rl;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] out_lane(int p, int w);
    logic signed [ACC_W-1:0] t;
    t = bus.out[(p*W+w)*ACC_W +: ACC_W];
    return t;
  endfunction

  function automatic longint lane_val(input logic [15:0] v, int i);
    logic signed [DW-1:0] t;
    t = v[i*DW +: DW];
    return longint'(t);
  endfunction

  function automatic longint wrap(input longint s);
    logic signed [ACC_W-1:0] t;
    t = s[ACC_W-1:0];
    return longint'(t);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      pa[p] = 0;
      for (int w = 0; w < W; w++) begin m_acc[p][w] = 0; m_out[p][w] = 0; end
    end
    for (int w = 0; w < W; w++) pb[w] = 0;
    {m_flag, m_sat, m_valid, pv, pf, pl, m_rv, m_rf, m_rl} = '0;
    m_bottom = '0;
    m_right  = '0;
  endtask

  task automatic model_edge(input bit e, v, f, l, input logic [P*DW-1:0] u, input logic [W*DW-1:0] lf);
    bit any;
    if (!reset) begin model_reset(); return; end
    if (!e) return;
    any = 1'b0;
    if (pv) begin
      for (int p = 0; p < P; p++)
        for (int w = 0; w < W; w++) begin
          longint s;
          s = (pf ? 64'sd0 : m_acc[p][w]) + pa[p] * pb[w];
          if (SAT) begin
            if (s > MAXV) begin s = MAXV; any = 1'b1; end
            else if (s < MINV) begin s = MINV; any = 1'b1; end
          end else s = wrap(s);
          m_acc[p][w] = s;
        end
      m_flag = (pf ? 1'b0 : m_flag) | any;
      if (pl) begin
        m_out = m_acc;
        m_sat = SAT & m_flag;
      end
    end
    m_valid = pv && pl;
    pv = v; pf = f; pl = l;
    for (int p = 0; p < P; p++) pa[p] = lane_val(u, p);
    for (int w = 0; w < W; w++) pb[w] = lane_val(lf, w);
    m_bottom = u; m_right = lf;
    m_rv = v; m_rf = f; m_rl = l;
  endtask

  task automatic check_all();
    check("bottom", bus.bottom, m_bottom);
    check("right", bus.right, m_right);
    check("right_ctl", {bus.right_valid, bus.right_first, bus.right_last}, {m_rv, m_rf, m_rl});
    check("out_valid", bus.out_valid, m_valid);
    check("out_sat", bus.out_sat, m_sat);
    for (int p = 0; p < P; p++)
      for (int w = 0; w < W; w++)
        check($sformatf("out_%0d_%0d", p, w), out_lane(p, w), m_out[p][w]);
  endtask

  task automatic beat(input bit e, v, f, l, input logic [P*DW-1:0] u, input logic [W*DW-1:0] lf);
    bus.en = e; bus.in_valid = v; bus.in_first = f; bus.in_last = l;
    bus.up = u; bus.left = lf;
    @(posedge clk);
    model_edge(e, v, f, l, u, lf);
    #1;
    if (e && bus.out_valid) pulses++;
    check_all();
  endtask

  task automatic rand_beat(input bit e);
    beat(e, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
         16'($urandom), 16'($urandom));
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.up = '0; bus.left = '0;
    model_reset();
    #2;
    check_all();

    // reset held with random activity
    for (int i = 0; i < 6; i++) rand_beat(i[0]);
    check("rst_out", bus.out, 0);
    reset = 1'b1;

    // forwarding and single-term frame
    beat(1, 1, 1, 1, 16'h0302, 16'hFF05);
    check("fwd_bottom", bus.bottom, 16'h0302);
    check("fwd_right", bus.right, 16'hFF05);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("single_ov", bus.out_valid, 1);
    check("single_00", out_lane(0, 0), 10);
    check("single_01", out_lane(0, 1), -2);
    check("single_10", out_lane(1, 0), 15);
    check("single_11", out_lane(1, 1), -3);

    // three terms with a bubble, then back-to-back single-term frame
    pulses = 0;
    beat(1, 1, 1, 0, 16'h0101, 16'h0404);
    beat(1, 1, 0, 0, 16'h0101, 16'h0404);
    beat(1, 0, 1, 1, 16'h0101, 16'h0404);
    beat(1, 1, 0, 1, 16'h0101, 16'h0404);
    beat(1, 1, 1, 1, 16'h0080, 16'h0080);
    for (int p = 0; p < P; p++)
      for (int w = 0; w < W; w++) check("three_term", out_lane(p, w), 12);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("b2b_00", out_lane(0, 0), 16384);
    check("b2b_11", out_lane(1, 1), 0);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("pulse_count", pulses, 2);

    // freeze mid-frame and while the result is visible
    pulses = 0;
    beat(1, 1, 1, 0, 16'h0302, 16'h0201);
    for (int i = 0; i < 3; i++) rand_beat(0);
    beat(1, 1, 0, 0, 16'h0302, 16'h0201);
    beat(1, 1, 0, 1, 16'h0302, 16'h0201);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      rand_beat(0);
      check("freeze_ov", bus.out_valid, 1);
    end
    check("freeze_00", out_lane(0, 0), 6);
    check("freeze_11", out_lane(1, 1), 18);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("freeze_drop", bus.out_valid, 0);
    check("freeze_pulses", pulses, 1);

    // overflow: three (-128)*(-128) terms
    beat(1, 1, 1, 0, 16'h8080, 16'h8080);
    beat(1, 1, 0, 0, 16'h8080, 16'h8080);
    beat(1, 1, 0, 1, 16'h8080, 16'h8080);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("ovf_00", out_lane(0, 0), SAT ? 32767 : -16384);
    check("ovf_sat", bus.out_sat, SAT);

    // reset mid-frame, then a fresh single-term frame
    beat(1, 1, 1, 0, 16'h0505, 16'h0505);
    beat(1, 1, 0, 0, 16'h0505, 16'h0505);
    async_reset();
    check("midrst_out", bus.out, 0);
    beat(1, 1, 1, 1, 16'h0007, 16'h0006);
    beat(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("midrst_00", out_lane(0, 0), 42);
    check("midrst_01", out_lane(0, 1), 0);
    check("midrst_sat", bus.out_sat, 0);

    // random traffic with occasional freezes and resets
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 150) == 0) async_reset();
      rand_beat(($urandom % 5) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
